wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage of the RISC-V core; sits between the memory stage and the general-purpose register file.
- Accepts one retiring instruction per handshake from MEM.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends it.
- Drives the register-file write port (wena/waddr/wdata) from registered outputs; the same values are exported as a forwarding bypass.

Parameters:
- XLEN, 32, data width; must match `DATA_BUS.
- REG_AW, 5, register address width; must match `REG_BUS.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid  in  1  MEM presents an instruction
- mem_ready  out  1  WB can accept this cycle
- mem_rd  in  REG_AW  destination register
- mem_rd_wen  in  1  instruction writes rd
- mem_is_load  in  1  result comes from data memory
- mem_funct3  in  3  load size/sign code
- mem_addr_lo  in  2  low bits of the load address
- mem_result  in  XLEN  ALU/CSR/link result for non-loads
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  raw aligned word from data memory
- wena  out  1  register-file write enable
- waddr  out  REG_AW  register-file write address
- wdata  out  XLEN  register-file write data
- fwd_valid, fwd_rd, fwd_data  out  1/REG_AW/XLEN  bypass to decode; equal to wena/waddr/wdata
- instret  out  64  retired-instruction count (see Optional Feature)

Behaviour:
- Reset: state IDLE, mem_ready=1, wena=0, waddr=0, wdata=0, instret=0.
- State machine (IDLE, WAIT_LOAD):
  - IDLE: mem_ready=1. On mem_valid with mem_is_load=0: next cycle wena=mem_rd_wen && (mem_rd!=0), waddr=mem_rd, wdata=mem_result; stay IDLE. Latency 1.
  - IDLE: on mem_valid with mem_is_load=1: latch rd, rd_wen, funct3, addr_lo; go to WAIT_LOAD; next cycle wena=0.
  - WAIT_LOAD: mem_ready=0; wena=0 every cycle until the response arrives.
  - WAIT_LOAD: on dmem_rvalid: next cycle wena=latched_wen && (rd!=0), wdata=extended load value; return to IDLE.
  - A new instruction is accepted in the cycle after the return to IDLE at the earliest.
- dmem_rvalid in IDLE is ignored. A response is never expected in the acceptance cycle.
- wena is a single-cycle pulse per retired instruction. waddr/wdata hold their last values while wena=0.
- rd=x0: write suppressed (wena=0), but the instruction still retires.
- Load extension:
  - funct3 000 LB: byte dmem_rdata[8*addr_lo +: 8], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at addr_lo[1], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW and unused codes (011/110/111): full word, addr_lo ignored.
- Reset in WAIT_LOAD: pending load discarded, no write, state IDLE; a late dmem_rvalid is ignored.
- Retirement is the cycle a non-load is accepted, or the cycle dmem_rvalid arrives in WAIT_LOAD.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined: 64-bit counter increments by 1 on each retirement (including rd=x0 and no-write instructions) and wraps at 2^64; it reads the new value one cycle after retirement.
- Undefined: no counter logic; instret tied to 0.

Decomposition:
- common.v holds `DATA_BUS, `REG_BUS, `REG_X0, `DATA_ZERO, and new load funct3 constants `F3_LB, `F3_LH, `F3_LW, `F3_LBU, `F3_LHU.
- One combinational sub-module, load_ext: inputs raw word, funct3, addr_lo; output extended value.

Test Plan:
- Non-load rd=5, result 0x12345678, mem_valid one cycle -> next cycle wena=1, waddr=5, wdata=0x12345678; following cycle wena=0.
- LB rd=3, addr_lo=2, rdata=0x00800000, rvalid 3 cycles later -> mem_ready=0 for those cycles; cycle after rvalid wena=1, wdata=0xFFFFFF80. Same with LBU -> 0x00000080.
- LH addr_lo=2, rdata=0x8001_0000 -> wdata=0xFFFF8001. LHU -> 0x00008001. LW addr_lo=3, rdata=0xDEADBEEF -> 0xDEADBEEF.
- rd=0 non-load with result 0xFFFFFFFF -> wena stays 0; instret still increments when WB_INSTRET_EN is defined.
- rst asserted in WAIT_LOAD, rvalid the cycle after reset -> no wena, mem_ready=1, instret=0.
- 4 back-to-back non-loads on rd=1..4 -> wena high 4 consecutive cycles with matching waddr; fwd_* equals wena/waddr/wdata each cycle; instret=4 (or 0 without WB_INSTRET_EN).

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage.
// Carries the data/register bus widths and the load funct3 encodings.
package wb_stage_pkg;

    localparam int DATA_BUS = 32;
    localparam int REG_BUS  = 5;

    localparam logic [REG_BUS-1:0]  REG_X0    = '0;
    localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_WAIT_LOAD
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data alignment and sign/zero extension for the writeback stage.
// Unused funct3 codes fall back to a full-word load.
module wb_stage_load_ext
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        unique case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires MEM instructions into the register file.
// Define WB_INSTRET_EN to build the 64-bit retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN   = DATA_BUS,
    parameter int REG_AW = REG_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_rd_wen,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_funct3,
    input  logic [1:0]        mem_addr_lo,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wena,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [63:0]       instret
);

    wb_state_e         state_q, state_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic              ld_wen_q, ld_wen_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_lo_q, ld_lo_d;
    logic              wena_q, wena_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              retire;
    logic [XLEN-1:0]   ld_data;

    wb_stage_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .rdata_i   (dmem_rdata),
        .funct3_i  (ld_f3_q),
        .addr_lo_i (ld_lo_q),
        .data_o    (ld_data)
    );

    always_comb begin
        state_d   = state_q;
        ld_rd_d   = ld_rd_q;
        ld_wen_d  = ld_wen_q;
        ld_f3_d   = ld_f3_q;
        ld_lo_d   = ld_lo_q;
        wena_d    = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        retire    = 1'b0;
        mem_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mem_ready = 1'b1;
                if (mem_valid && !mem_is_load) begin
                    retire = 1'b1;
                    // x0 and no-write ops retire but leave waddr/wdata untouched
                    if (mem_rd_wen && (mem_rd != '0)) begin
                        wena_d  = 1'b1;
                        waddr_d = mem_rd;
                        wdata_d = mem_result;
                    end
                end else if (mem_valid) begin
                    ld_rd_d  = mem_rd;
                    ld_wen_d = mem_rd_wen;
                    ld_f3_d  = mem_funct3;
                    ld_lo_d  = mem_addr_lo;
                    state_d  = S_WAIT_LOAD;
                end
            end
            S_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                    if (ld_wen_q && (ld_rd_q != '0)) begin
                        wena_d  = 1'b1;
                        waddr_d = ld_rd_q;
                        wdata_d = ld_data;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ld_rd_q  <= '0;
            ld_wen_q <= 1'b0;
            ld_f3_q  <= '0;
            ld_lo_q  <= '0;
            wena_q   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ld_rd_q  <= ld_rd_d;
            ld_wen_q <= ld_wen_d;
            ld_f3_q  <= ld_f3_d;
            ld_lo_q  <= ld_lo_d;
            wena_q   <= wena_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret       = '0;
`endif

    assign wena      = wena_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign fwd_valid = wena_q;
    assign fwd_rd    = waddr_q;
    assign fwd_data  = wdata_q;

endmodule
